// File: rtl/dsp_seq_pkg.sv
// Shared types and constants for the MAC sequencer and the slice it drives.
package dsp_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_RESULT = 3'd4
  } seq_state_e;

  // Slice operating modes (one-hot mode select on the slice).
  localparam logic [2:0] MODE_ADD = 3'b001;
  localparam logic [2:0] MODE_MUL = 3'b010;
  localparam logic [2:0] MODE_MAC = 3'b100;

  // Slice latency from operand presentation to accumulator output.
  localparam int DRAIN_CYCLES = 3;
  localparam int DRAIN_W      = $clog2(DRAIN_CYCLES);

endpackage

// File: rtl/dsp_mac_sequencer.sv
// Command-driven initiator: clears a dsp_slice, streams operand pairs into
// it in MAC mode, waits out the slice pipeline and returns the accumulator.
module dsp_mac_sequencer
  import dsp_seq_pkg::*;
#(
  parameter int DWIDTH = 16,
  parameter int LEN_W  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  // command port
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [LEN_W-1:0]         cmd_len,
  // operand stream
  input  logic                     op_valid,
  output logic                     op_ready,
  input  logic signed [DWIDTH-1:0] op_a,
  input  logic signed [DWIDTH-1:0] op_b,
  // result port
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [DWIDTH-1:0]        res_data,
  // slice side
  output logic                     slice_reset,
  output logic [2:0]               slice_mode,
  output logic [DWIDTH-1:0]        slice_a,
  output logic [DWIDTH-1:0]        slice_b,
  output logic                     slice_carry_in,
  input  logic [DWIDTH-1:0]        slice_c_out
);

  seq_state_e         state_q, state_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic [DWIDTH-1:0]  res_q, res_d;
  logic               op_fire;

  // State, pair count, drain counter and captured result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      drain_q <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      drain_q <= drain_d;
      res_q   <= res_d;
    end
  end

  // Next-state and handshake/slice outputs; operands are zero except on an
  // accepted pair so idle cycles add 0*0 to the accumulator.
  always_comb begin
    state_d        = state_q;
    rem_d          = rem_q;
    drain_d        = drain_q;
    res_d          = res_q;
    cmd_ready      = 1'b0;
    op_ready       = 1'b0;
    res_valid      = 1'b0;
    op_fire        = 1'b0;
    slice_a        = '0;
    slice_b        = '0;
    slice_mode     = MODE_MAC;
    slice_carry_in = 1'b0;
    slice_reset    = reset;

    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          rem_d   = cmd_len;
          state_d = ST_CLEAR;
        end
      end

      ST_CLEAR: begin
        slice_reset = 1'b1;
        drain_d     = '0;
        state_d     = (rem_q != '0) ? ST_STREAM : ST_DRAIN;
      end

      ST_STREAM: begin
        op_ready = 1'b1;
        op_fire  = op_valid;
        if (op_fire) begin
          slice_a = op_a;
          slice_b = op_b;
          rem_d   = rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) begin
            drain_d = '0;
            state_d = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        drain_d = drain_q + 1'b1;
        // Last drain cycle: the final pair is now visible on slice_c_out.
        if (drain_q == DRAIN_W'(DRAIN_CYCLES - 1)) begin
          drain_d = '0;
          res_d   = slice_c_out;
          state_d = ST_RESULT;
        end
      end

      ST_RESULT: begin
        res_valid = 1'b1;
        if (res_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign res_data = res_q;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed bench for dsp_mac_sequencer with a behavioral 3-stage MAC slice.
module tb_dsp_mac_sequencer;

  localparam int DW = 16;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready;
  logic [LW-1:0] cmd_len;
  logic          op_valid, op_ready;
  logic [DW-1:0] op_a, op_b;
  logic          res_valid, res_ready;
  logic [DW-1:0] res_data;
  logic          slice_reset;
  logic [2:0]    slice_mode;
  logic [DW-1:0] slice_a, slice_b;
  logic          slice_carry_in;
  logic [DW-1:0] slice_c_out;

  int n_vec = 0;
  int n_err = 0;
  int cnt   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cnt <= cnt + 1;

  dsp_mac_sequencer #(.DWIDTH(DW), .LEN_W(LW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .slice_reset(slice_reset), .slice_mode(slice_mode),
    .slice_a(slice_a), .slice_b(slice_b),
    .slice_carry_in(slice_carry_in), .slice_c_out(slice_c_out)
  );

  // Slice model: operand reg -> saturated product reg -> wrapping accumulator.
  logic [DW-1:0] s_a1, s_b1, s_p2, s_acc;

  function automatic logic [DW-1:0] sat16(input int p);
    if (p > 32767)  return 16'h7FFF;
    if (p < -32768) return 16'h8000;
    return p[DW-1:0];
  endfunction

  always @(posedge clk) begin
    if (slice_reset) begin
      s_a1 <= '0; s_b1 <= '0; s_p2 <= '0; s_acc <= '0;
    end else begin
      s_a1  <= slice_a;
      s_b1  <= slice_b;
      s_p2  <= sat16(int'($signed(s_a1)) * int'($signed(s_b1)));
      s_acc <= s_acc + s_p2;
    end
  end
  assign slice_c_out = s_acc;

  // op_ready monitor for the empty-command case.
  logic mon_op = 1'b0, op_seen = 1'b0;
  always @(negedge clk) if (mon_op && op_ready) op_seen <= 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic issue(input logic [LW-1:0] len, output int acc_c);
    int n = 0;
    cmd_valid = 1'b1; cmd_len = len; settle();
    while (!cmd_ready && n < 50) begin tick(); settle(); n++; end
    if (!cmd_ready) chk("cmd_timeout", 32'd0, 32'd1);
    acc_c = cnt;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input int bubbles, output int acc_c);
    int n = 0;
    for (int i = 0; i < bubbles; i++) begin
      op_valid = 1'b0; op_a = 16'h5555; op_b = 16'hAAAA; settle();
      chk("bubble_a", {16'd0, slice_a}, 32'd0);
      chk("bubble_b", {16'd0, slice_b}, 32'd0);
      tick();
    end
    op_valid = 1'b1; op_a = a; op_b = b; settle();
    while (!op_ready && n < 50) begin tick(); settle(); n++; end
    if (!op_ready) chk("op_timeout", 32'd0, 32'd1);
    chk("pair_a", {16'd0, slice_a}, {16'd0, a});
    acc_c = cnt;
    tick();
    op_valid = 1'b0; op_a = '0; op_b = '0;
  endtask

  task automatic wait_res(output int seen_c);
    int n = 0;
    settle();
    while (!res_valid && n < 100) begin tick(); settle(); n++; end
    if (!res_valid) chk("res_timeout", 32'd0, 32'd1);
    seen_c = cnt;
  endtask

  task automatic take_res();
    res_ready = 1'b1; tick(); res_ready = 1'b0;
  endtask

  int c_acc, c_last, c_seen, c_hs;
  logic bp_ok;

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_len = '0; op_valid = 1'b0;
    op_a = '0; op_b = '0; res_ready = 1'b0;
    tick(); tick(); settle();
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_op_ready", {31'd0, op_ready}, 32'd0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_res_data", {16'd0, res_data}, 32'd0);
    chk("rst_slice_reset", {31'd0, slice_reset}, 32'd1);
    chk("rst_slice_a", {16'd0, slice_a}, 32'd0);
    chk("rst_mode", {29'd0, slice_mode}, 32'h4);
    chk("rst_cin", {31'd0, slice_carry_in}, 32'd0);
    reset = 1'b0; tick();

    // Basic dot product: 2*3 + 4*5 + (-1)*7 = 19.
    issue(8'd3, c_acc); settle();
    chk("clear_slice_reset", {31'd0, slice_reset}, 32'd1);
    chk("clear_op_ready", {31'd0, op_ready}, 32'd0);
    push(16'd2, 16'd3, 0, c_last);
    chk("basic_first_pair_cyc", c_last - c_acc, 32'd2);
    push(16'd4, 16'd5, 0, c_last);
    push(16'hFFFF, 16'd7, 0, c_last);
    wait_res(c_seen);
    chk("basic_lat_last", c_seen - c_last, 32'd4);
    chk("basic_lat_cmd", c_seen - c_acc, 32'd8);
    chk("basic_data", {16'd0, res_data}, 32'h0013);
    take_res(); settle();
    chk("basic_idle", {31'd0, cmd_ready}, 32'd1);

    // Same pairs with 2-cycle bubbles between them.
    issue(8'd3, c_acc);
    push(16'd2, 16'd3, 0, c_last);
    push(16'd4, 16'd5, 2, c_last);
    push(16'hFFFF, 16'd7, 2, c_last);
    wait_res(c_seen);
    chk("bubble_lat", c_seen - c_last, 32'd4);
    chk("bubble_data", {16'd0, res_data}, 32'h0013);
    take_res();

    // Empty command.
    mon_op = 1'b1;
    issue(8'd0, c_acc);
    wait_res(c_seen);
    chk("empty_lat", c_seen - c_acc, 32'd5);
    chk("empty_data", {16'd0, res_data}, 32'h0000);
    mon_op = 1'b0;
    chk("empty_no_op_ready", {31'd0, op_seen}, 32'd0);
    take_res();

    // Saturated product, then back-to-back command right after the handshake.
    issue(8'd1, c_acc);
    push(16'd300, 16'd300, 0, c_last);
    wait_res(c_seen);
    chk("sat_data", {16'd0, res_data}, 32'h7FFF);
    c_hs = cnt;
    take_res();
    issue(8'd1, c_acc);
    chk("b2b_accept_cyc", c_acc - c_hs, 32'd1);
    push(16'd1, 16'd1, 0, c_last);
    wait_res(c_seen);
    chk("b2b_data", {16'd0, res_data}, 32'h0001);
    take_res();

    // Backpressure: result held 10 cycles while a new command is offered.
    issue(8'd1, c_acc);
    push(16'd5, 16'd5, 0, c_last);
    wait_res(c_seen);
    cmd_valid = 1'b1; cmd_len = 8'd1;
    bp_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      settle();
      if (res_data !== 16'h0019 || res_valid !== 1'b1 || cmd_ready !== 1'b0) bp_ok = 1'b0;
      tick();
    end
    chk("bp_hold", {31'd0, bp_ok}, 32'd1);
    chk("bp_data", {16'd0, res_data}, 32'h0019);
    take_res(); settle();
    chk("bp_stalled_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    tick(); cmd_valid = 1'b0; settle();
    chk("bp_stalled_taken", {31'd0, slice_reset}, 32'd1);
    push(16'd7, 16'd3, 0, c_last);
    wait_res(c_seen);
    chk("bp_next_data", {16'd0, res_data}, 32'h0015);
    take_res();

    // Reset after 2 of 5 pairs, then a fresh command.
    issue(8'd5, c_acc);
    push(16'd9, 16'd9, 0, c_last);
    push(16'd8, 16'd8, 0, c_last);
    reset = 1'b1; tick(); settle();
    chk("mid_rst_idle", {31'd0, cmd_ready}, 32'd1);
    chk("mid_rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("mid_rst_slice_reset", {31'd0, slice_reset}, 32'd1);
    chk("mid_rst_op_ready", {31'd0, op_ready}, 32'd0);
    reset = 1'b0; tick();
    issue(8'd2, c_acc);
    push(16'd3, 16'd3, 0, c_last);
    push(16'd2, 16'd2, 0, c_last);
    wait_res(c_seen);
    chk("post_rst_data", {16'd0, res_data}, 32'h000D);
    take_res();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dsp_mac_sequencer.md
# dsp_mac_sequencer

Command-driven initiator that runs one dsp_slice in MAC mode to compute dot products of signed DWIDTH-bit operand streams. It accepts a length command, clears the slice, streams operand pairs into it, waits out the slice pipeline, and returns the accumulated slice output on a valid/ready result port. It sits between the operand-fetch logic and a dsp_slice instance and is the only agent driving that slice.

## Interface
- DWIDTH, 16, operand and result width; must equal the slice width
- LEN_W, 8, width of the pair-count field

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_len  in  LEN_W  number of operand pairs, 0 to 2^LEN_W-1
- op_valid  in  1  operand pair offered
- op_ready  out  1  pair accepted when high with op_valid
- op_a, op_b  in  DWIDTH each  signed operands
- res_valid  out  1  result available
- res_ready  in  1  result consumed when high with res_valid
- res_data  out  DWIDTH  accumulated slice output
- slice_reset  out  1  synchronous clear to the slice
- slice_mode  out  3  constant 3'b100 (MAC)
- slice_a, slice_b  out  DWIDTH each  slice operands
- slice_carry_in  out  1  constant 0
- slice_c_out  in  DWIDTH  slice accumulator output

## Operation
- States: IDLE, CLEAR, STREAM, DRAIN, RESULT.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch cmd_len into remaining and go to CLEAR.
- CLEAR: one cycle, slice_reset=1. Next state is STREAM if remaining>0, else DRAIN.
- STREAM:
  - op_ready=1.
  - Each accepted pair drives slice_a/slice_b combinationally with op_a/op_b in the same cycle and decrements remaining.
  - Cycles without an accepted pair drive 0/0. A 0*0 product adds nothing, so bubbles are harmless.
  - After the pair that takes remaining to 0 is accepted, go to DRAIN.
- DRAIN:
  - Runs exactly DRAIN_CYCLES=3 cycles, driving slice_a/slice_b=0.
  - At the end of the third cycle, register slice_c_out into res_data and go to RESULT.
- RESULT:
  - res_valid=1, and res_data is held stable.
  - On res_ready, go to IDLE.
- slice_reset = reset | (state==CLEAR). The slice therefore clears whenever the sequencer resets.
- slice_a/slice_b are 0 in every state other than accepted STREAM cycles.
- Arithmetic belongs entirely to the slice:
  - Each product saturates to the signed DWIDTH range.
  - The accumulator wraps modulo 2^DWIDTH.
  - The sequencer does no arithmetic on results.
- cmd_ready is 0 outside IDLE. A command offered while busy is stalled, not dropped.

## Timing
- Reset values:
  - state = IDLE, so cmd_ready = 1.
  - op_ready = 0, res_valid = 0, res_data = 0, slice_reset = 1 (while reset is high).
  - slice_a = 0, slice_b = 0, slice_mode = 3'b100, slice_carry_in = 0.
- Command accepted in cycle c: CLEAR in cycle c+1; STREAM starts in c+2.
- Slice pipeline: a pair presented in cycle k is reflected in slice_c_out from cycle k+3.
- Last pair accepted in cycle L:
  - DRAIN runs in cycles L+1 to L+3.
  - res_data is captured at the end of L+3.
  - res_valid is high from L+4.
- With no bubbles and an immediate res_ready, a command takes N+6 cycles from acceptance to returning to IDLE.
- cmd_len=0: CLEAR in c+1, DRAIN in c+2 to c+4, res_valid in c+5 with res_data=0.
- Back-to-back commands: the earliest next acceptance is the cycle after the res handshake. Each command is preceded by CLEAR, so results are independent.
- Reset mid-operation:
  - Takes effect on the next edge regardless of state.
  - A pending result is discarded and res_valid drops.
  - The slice is cleared by slice_reset.

## Structure
- Shared package dsp_seq_pkg holds:
  - the state enum;
  - the slice mode constants MODE_ADD=3'b001, MODE_MUL=3'b010, MODE_MAC=3'b100;
  - DRAIN_CYCLES=3.
- Sub-modules: none inside the sequencer.
- The bench top dsp_mac_unit instantiates dsp_mac_sequencer and dsp_slice side by side, with matching DWIDTH.

## Test plan
- Basic dot product: cmd_len=3, pairs (2,3), (4,5), (-1,7) with no bubbles -> res_data=0x0013, res_valid exactly 4 cycles after the last pair is accepted.
- Bubbles: the same pairs with op_valid low for 2 cycles between each pair -> res_data=0x0013; slice_a/slice_b are 0 during the bubbles.
- Empty command: cmd_len=0 -> res_valid 5 cycles after acceptance, res_data=0x0000, op_ready never high.
- Saturation and back-to-back: command 1 is cmd_len=1, pair (300,300) -> res_data=0x7FFF. Command 2 is cmd_len=1, pair (1,1), issued right after the handshake -> res_data=0x0001 (the CLEAR is effective).
- Backpressure: hold res_ready low for 10 cycles -> res_data stable, cmd_ready=0, and cmd_valid is stalled throughout.
- Reset mid-stream: assert reset after 2 of 5 pairs have been accepted. Response: next cycle state is IDLE, res_valid=0, slice_reset=1. A following cmd_len=2 with pairs (3,3), (2,2) -> res_data=0x000D.
